// File: rtl/sa_pkg.sv
// Shared types and helpers for the weight-stationary systolic array.
// Optional macro SA_SATURATE_EN: enables the saturating PE accumulate helper.
package sa_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned ACC_W_DEF = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } sa_state_e;

  // Cycles from vector acceptance to its deskewed result.
  function automatic int unsigned sa_lat(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

`ifdef SA_SATURATE_EN
  // Signed add clamped to the range of a w-bit two's complement value.
  function automatic logic signed [63:0] sa_sat_add(input logic signed [63:0] a,
                                                    input logic signed [63:0] b,
                                                    input int unsigned        w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction
`endif

endpackage

// File: rtl/sa_pe_ws.sv
// One weight-stationary PE: shift-in weight, forwarded activation, signed MAC.
// Optional macro SA_SATURATE_EN: accumulate saturates instead of wrapping.
module sa_pe_ws
  import sa_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_clr_i,
  input  logic                    w_shift_i,
  input  logic signed [DW-1:0]    w_i,
  output logic signed [DW-1:0]    w_o,
  input  logic signed [DW-1:0]    act_i,
  output logic signed [DW-1:0]    act_o,
  input  logic signed [ACC_W-1:0] psum_i,
  input  logic                    psum_en_i,
  output logic signed [ACC_W-1:0] psum_o
);

  logic signed [DW-1:0]    w_q;
  logic signed [DW-1:0]    a_q;
  logic signed [ACC_W-1:0] p_q;
  logic signed [ACC_W-1:0] p_d;
  logic signed [2*DW-1:0]  prod;

  // Multiply the incoming activation by the resident weight and add the psum from above.
  always_comb begin
    prod = (2*DW)'(act_i) * (2*DW)'(w_q);
`ifdef SA_SATURATE_EN
    p_d  = ACC_W'(sa_sat_add(64'(psum_i), 64'(prod), ACC_W));
`else
    p_d  = psum_i + ACC_W'(prod);
`endif
  end

  // Weight, activation and psum registers; clear only flushes the weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      a_q <= '0;
      p_q <= '0;
    end else begin
      if (w_clr_i)        w_q <= '0;
      else if (w_shift_i) w_q <= w_i;
      a_q <= act_i;
      if (psum_en_i)      p_q <= p_d;
    end
  end

  assign w_o    = w_q;
  assign act_o  = a_q;
  assign psum_o = p_q;

endmodule

// File: rtl/sa_ws_array_ctrl.sv
// ROWS x COLS weight-stationary systolic array with load sequencer, skew/deskew
// and valid/ready handshakes. Optional macro SA_SATURATE_EN: saturating PE adds.
module sa_ws_array_ctrl
  import sa_pkg::*;
#(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load_start,
  output logic                  load_ready,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [COLS*DW-1:0]    w_in,
  input  logic                  act_valid,
  output logic                  act_ready,
  input  logic [ROWS*DW-1:0]    act_in,
  output logic                  out_valid,
  output logic [COLS*ACC_W-1:0] psum_out,
  output logic                  weights_loaded
);

  localparam int unsigned L  = sa_lat(ROWS, COLS);
  localparam int unsigned IW = $clog2(L + 1);
  localparam int unsigned CW = $clog2(ROWS);

  sa_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  inflight_q, inflight_d;
  logic [L-1:0]   vld_q;
  logic           load_fire, w_fire, accept;

  logic signed [DW-1:0]    skew_out  [ROWS];
  logic signed [DW-1:0]    w_grid    [ROWS][COLS];
  logic signed [DW-1:0]    act_grid  [ROWS][COLS];
  logic signed [ACC_W-1:0] psum_grid [ROWS][COLS];
  logic signed [ACC_W-1:0] col_res   [COLS];

  // Handshake decodes; weight beats wait for an empty pipe so resident weights never move under data.
  assign load_ready     = (state_q != LOAD) && (inflight_q == '0);
  assign w_ready        = (state_q == LOAD) && (inflight_q == '0);
  assign act_ready      = (state_q == READY);
  assign weights_loaded = (state_q == READY);
  assign out_valid      = vld_q[L-1];
  assign load_fire      = load_start && load_ready && !clear;
  assign w_fire         = w_valid && w_ready && !clear;
  assign accept         = act_valid && act_ready && !clear;

  // Next state and beat counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (w_fire) begin
            if (cnt_q == CW'(ROWS - 1)) begin
              state_d = READY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          if (load_fire) begin
            state_d = LOAD;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // In-flight vector count: up on accept, down on output.
  always_comb begin
    inflight_d = inflight_q;
    if (clear)                    inflight_d = '0;
    else if (accept && !out_valid) inflight_d = inflight_q + IW'(1);
    else if (!accept && out_valid) inflight_d = inflight_q - IW'(1);
  end

  // Control registers and the valid shift pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      inflight_q <= '0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      vld_q      <= clear ? '0 : {vld_q[L-2:0], accept};
    end
  end

  // Input skew: row r delayed r cycles, bubbles enter as zero.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic signed [DW-1:0] lane;
    assign lane = accept ? act_in[r*DW +: DW] : '0;
    if (r == 0) begin : g_direct
      assign skew_out[r] = lane;
    end else begin : g_dly
      logic signed [DW-1:0] sk_q [r];
      // Skew delay line for this row.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < r; i++) sk_q[i] <= '0;
        end else begin
          sk_q[0] <= lane;
          for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign skew_out[r] = sk_q[r-1];
    end
  end

  // PE grid: weights shift down, activations shift right, psums shift down.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [DW-1:0]    a_src, w_src;
      logic signed [ACC_W-1:0] p_src;
      logic                    p_en;

      if (c == 0) begin : g_a0
        assign a_src = skew_out[r];
      end else begin : g_an
        assign a_src = act_grid[r][c-1];
      end

      if (r == 0) begin : g_top
        assign w_src = w_in[c*DW +: DW];
        assign p_src = '0;
      end else begin : g_mid
        assign w_src = w_grid[r-1][c];
        assign p_src = psum_grid[r-1][c];
      end

      // Bottom row holds its result between valid vectors so outputs hold too.
      if (r == ROWS - 1) begin : g_bot
        assign p_en = vld_q[ROWS-2+c] && !clear;
      end else begin : g_run
        assign p_en = 1'b1;
      end

      sa_pe_ws #(.DW(DW), .ACC_W(ACC_W)) u_pe (
        .clk       (clk),
        .rst_n     (rst),
        .w_clr_i   (clear),
        .w_shift_i (w_fire),
        .w_i       (w_src),
        .w_o       (w_grid[r][c]),
        .act_i     (a_src),
        .act_o     (act_grid[r][c]),
        .psum_i    (p_src),
        .psum_en_i (p_en),
        .psum_o    (psum_grid[r][c])
      );
    end
  end

  // Output deskew: column c delayed COLS-1-c cycles, each stage advancing only with its vector.
  for (genvar c = 0; c < COLS; c++) begin : g_dsk
    localparam int unsigned D = COLS - 1 - c;
    if (D == 0) begin : g_direct
      assign col_res[c] = psum_grid[ROWS-1][c];
    end else begin : g_dly
      logic signed [ACC_W-1:0] dk_q [D];
      // Deskew stages gated by the matching valid bit.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < D; i++) dk_q[i] <= '0;
        end else begin
          for (int i = 0; i < D; i++) begin
            if (vld_q[ROWS-1+c+i] && !clear) begin
              dk_q[i] <= (i == 0) ? psum_grid[ROWS-1][c] : dk_q[(i == 0) ? 0 : i-1];
            end
          end
        end
      end
      assign col_res[c] = dk_q[D-1];
    end
  end

  // Pack column results onto the output bus.
  always_comb begin
    psum_out = '0;
    for (int c = 0; c < COLS; c++) psum_out[c*ACC_W +: ACC_W] = col_res[c];
  end

endmodule

// File: tb/tb_sa_ws_array_ctrl.sv
// Directed bench for sa_ws_array_ctrl (4x4, DW=8, ACC_W=16).
module tb_sa_ws_array_ctrl;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned ACC_W = 16;
  localparam int unsigned LAT   = ROWS + COLS - 1;

  typedef struct packed {
    logic [3:0][7:0]  a;
    logic [3:0][15:0] e;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clear;
  logic                  load_start;
  logic                  load_ready;
  logic                  w_valid;
  logic                  w_ready;
  logic [COLS*DW-1:0]    w_in;
  logic                  act_valid;
  logic                  act_ready;
  logic [ROWS*DW-1:0]    act_in;
  logic                  out_valid;
  logic [COLS*ACC_W-1:0] psum_out;
  logic                  weights_loaded;

  int   n_chk = 0;
  int   n_err = 0;
  int   wm [4][4];
  vec_t tbl [5];
  vec_t sv [$];
  int   ovf_e;

  always #5 clk = ~clk;

  sa_ws_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .load_start     (load_start),
    .load_ready     (load_ready),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .w_in           (w_in),
    .act_valid      (act_valid),
    .act_ready      (act_ready),
    .act_in         (act_in),
    .out_valid      (out_valid),
    .psum_out       (psum_out),
    .weights_loaded (weights_loaded)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.a[0] = 8'(a0);  v.a[1] = 8'(a1);  v.a[2] = 8'(a2);  v.a[3] = 8'(a3);
    v.e[0] = 16'(e0); v.e[1] = 16'(e1); v.e[2] = 16'(e2); v.e[3] = 16'(e3);
    return v;
  endfunction

  task automatic fill_w(input int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wm[r][c] = v;
  endtask

  // Beat k carries matrix row 3-k; optional one-cycle gap before beat 2.
  task automatic send_beats(input bit gap);
    for (int k = 0; k < 4; k++) begin
      if (gap && k == 2) begin
        w_valid = 1'b0;
        tick();
        chk("w_ready during gap", 64'(w_ready), 64'(1));
        chk("loaded during gap", 64'(weights_loaded), 64'(0));
      end
      w_valid = 1'b1;
      for (int c = 0; c < 4; c++) w_in[c*8 +: 8] = 8'(wm[3-k][c]);
      tick();
    end
    w_valid = 1'b0;
    w_in    = '0;
    chk("weights_loaded", 64'(weights_loaded), 64'(1));
    chk("act_ready in READY", 64'(act_ready), 64'(1));
  endtask

  task automatic load_w(input bit gap);
    chk("load_ready before load", 64'(load_ready), 64'(1));
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("w_ready in LOAD", 64'(w_ready), 64'(1));
    chk("act_ready in LOAD", 64'(act_ready), 64'(0));
    send_beats(gap);
  endtask

  // Stream sv back-to-back; result j is due LAT cycles after its accept and then held.
  task automatic run_stream(input string tag);
    int          n;
    int          j;
    bit          seen;
    bit          exp_v;
    logic [63:0] last;
    n    = sv.size();
    seen = 1'b0;
    last = '0;
    for (int cyc = 0; cyc < n + int'(LAT) + 2; cyc++) begin
      if (cyc < n) begin
        act_valid = 1'b1;
        act_in    = sv[cyc].a;
      end else begin
        act_valid = 1'b0;
        act_in    = '0;
      end
      tick();
      j     = cyc - int'(LAT - 1);
      exp_v = (j >= 0) && (j < n);
      chk({tag, " out_valid"}, 64'(out_valid), 64'(exp_v));
      if (exp_v) begin
        chk({tag, " psum"}, psum_out, sv[j].e);
        last = sv[j].e;
        seen = 1'b1;
      end else if (seen) begin
        chk({tag, " psum hold"}, psum_out, last);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef SA_SATURATE_EN
    ovf_e = 32767;
`else
    ovf_e = 0;
`endif
    wm = '{'{1, 2, 0, -1}, '{0, 1, 3, 2}, '{-2, 0, 1, 1}, '{1, -1, 2, 0}};
    tbl[0] = mk(1, 1, 1, 1,       0, 2, 6, 2);
    tbl[1] = mk(2, -3, 4, 5,      -1, -4, 5, -4);
    tbl[2] = mk(127, -128, 0, 0,  127, 126, -384, -383);
    tbl[3] = mk(-1, -1, -1, -1,   0, -2, -6, -2);
    tbl[4] = mk(10, 0, 0, -7,     3, 27, -14, -10);

    rst = 1'b0; clear = 1'b0; load_start = 1'b0; w_valid = 1'b0; w_in = '0;
    act_valid = 1'b0; act_in = '0;
    #3;
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset psum_out", psum_out, 64'(0));
    chk("reset w_ready", 64'(w_ready), 64'(0));
    chk("reset act_ready", 64'(act_ready), 64'(0));
    chk("reset weights_loaded", 64'(weights_loaded), 64'(0));
    chk("reset load_ready", 64'(load_ready), 64'(1));
    #4 rst = 1'b1;
    tick();

    // General matrix with a stalled beat, then the table streamed back-to-back.
    load_w(1'b1);
    sv.delete();
    for (int i = 0; i < 5; i++) sv.push_back(tbl[i]);
    run_stream("table");

    // Reload requested right after an accept waits for the pipe to drain.
    act_valid = 1'b1;
    act_in    = tbl[1].a;
    tick();
    act_valid  = 1'b0;
    act_in     = '0;
    load_start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("holdoff load_ready", 64'(load_ready), 64'(i == 8));
      chk("holdoff out_valid", 64'(out_valid), 64'(i == 7));
      if (i == 7) chk("holdoff psum", psum_out, tbl[1].e);
      tick();
    end
    load_start = 1'b0;
    chk("LOAD after drain", 64'(w_ready), 64'(1));
    wm = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
    send_beats(1'b0);
    chk("old result kept", psum_out, tbl[1].e);
    sv.delete();
    sv.push_back(mk(1, 2, 3, 4, 1, 2, 3, 4));
    run_stream("identity");

    // Signed extremes overflow the 16-bit accumulator.
    fill_w(-128);
    load_w(1'b0);
    sv.delete();
    sv.push_back(mk(-128, -128, -128, -128, ovf_e, ovf_e, ovf_e, ovf_e));
    run_stream("overflow");

    // All-ones weights, eight consecutive vectors.
    fill_w(1);
    load_w(1'b0);
    sv.delete();
    for (int k = 1; k <= 8; k++) sv.push_back(mk(k, k, k, k, 4*k, 4*k, 4*k, 4*k));
    run_stream("b2b");

    // clear three cycles after an accept discards the vector.
    act_valid = 1'b1;
    act_in    = tbl[0].a;
    tick();
    act_valid = 1'b0;
    act_in    = '0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear weights_loaded", 64'(weights_loaded), 64'(0));
    chk("clear load_ready", 64'(load_ready), 64'(1));
    chk("clear act_ready", 64'(act_ready), 64'(0));
    chk("clear w_ready", 64'(w_ready), 64'(0));
    for (int i = 0; i < 10; i++) begin
      chk("clear out_valid", 64'(out_valid), 64'(0));
      chk("clear psum hold", psum_out, mk(8, 8, 8, 8, 32, 32, 32, 32).e);
      tick();
    end

    // Async reset in the middle of a load, then a fresh load.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    w_valid    = 1'b1;
    w_in       = '1;
    tick();
    tick();
    w_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst out_valid", 64'(out_valid), 64'(0));
    chk("arst psum_out", psum_out, 64'(0));
    chk("arst w_ready", 64'(w_ready), 64'(0));
    chk("arst act_ready", 64'(act_ready), 64'(0));
    chk("arst weights_loaded", 64'(weights_loaded), 64'(0));
    chk("arst load_ready", 64'(load_ready), 64'(1));
    #2 rst = 1'b1;
    tick();
    wm = '{'{1, 2, 0, -1}, '{0, 1, 3, 2}, '{-2, 0, 1, 1}, '{1, -1, 2, 0}};
    load_w(1'b0);
    sv.delete();
    sv.push_back(tbl[0]);
    sv.push_back(tbl[2]);
    sv.push_back(tbl[4]);
    run_stream("after reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
